// File: rtl/vga_mode_sequencer.sv
// VGA timing-mode owner: applies requested modes at frame boundaries and holds the generator in reset meanwhile.
// Optional post-apply blanking phase is enabled by defining VGA_MODE_BLANK_EN.
module vga_mode_sequencer #(
    parameter int unsigned DEFAULT_MODE = 3,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned BLANK_FRAMES = 2,
    parameter int unsigned WAIT_TIMEOUT = 1500000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_frame_end,
    input  logic        i_mode_req,
    input  logic [1:0]  i_mode_sel,
    output logic        o_mode_ack,
    output logic        o_busy,
    output logic [1:0]  o_cur_mode,
    output logic        o_gen_rst_n,
    output logic        o_blank_out,
    output logic [10:0] o_h_display,
    output logic [10:0] o_h_front,
    output logic [10:0] o_h_sync,
    output logic [10:0] o_h_back,
    output logic [9:0]  o_v_display,
    output logic [9:0]  o_v_front,
    output logic [9:0]  o_v_sync,
    output logic [9:0]  o_v_back
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
`ifdef VGA_MODE_BLANK_EN
        , ST_BLANK
`endif
    } state_t;

    typedef struct packed {
        logic [10:0] hd, hf, hs, hb;
        logic [9:0]  vd, vf, vs, vb;
    } timing_t;

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(WAIT_TIMEOUT - 1);
    localparam logic [1:0]    DEF_MODE  = 2'(DEFAULT_MODE);

    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd0:    t = {11'd640,  11'd16, 11'd96,  11'd48,  10'd480, 10'd10, 10'd2, 10'd33};
            2'd1:    t = {11'd800,  11'd40, 11'd128, 11'd88,  10'd600, 10'd1,  10'd4, 10'd23};
            2'd2:    t = {11'd1024, 11'd24, 11'd136, 11'd160, 10'd768, 10'd3,  10'd6, 10'd29};
            2'd3:    t = {11'd1024, 11'd48, 11'd32,  11'd80,  10'd768, 10'd3,  10'd4, 10'd15};
            default: t = {11'd640,  11'd16, 11'd96,  11'd48,  10'd480, 10'd10, 10'd2, 10'd33};
        endcase
        return t;
    endfunction

    state_t        r_state, w_state;
    logic          r_boot, w_boot;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt;
    logic [TW-1:0] r_to_cnt, w_to_cnt;
    logic [1:0]    r_pending, w_pending;
    timing_t       r_timing, w_timing;
    logic [1:0]    r_cur_mode, w_cur_mode;
    logic          r_gen_rst_n, w_gen_rst_n;
    logic          r_blank, w_blank;
    logic          r_ack, w_ack;
    logic          r_busy, w_busy;
`ifdef VGA_MODE_BLANK_EN
    localparam int unsigned FW = $clog2(BLANK_FRAMES + 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLANK_FRAMES - 1);
    logic [FW-1:0] r_frm_cnt, w_frm_cnt;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state     = r_state;
        w_boot      = r_boot;
        w_hold_cnt  = r_hold_cnt;
        w_to_cnt    = r_to_cnt;
        w_pending   = r_pending;
        w_timing    = r_timing;
        w_cur_mode  = r_cur_mode;
        w_gen_rst_n = r_gen_rst_n;
        w_blank     = r_blank;
        w_ack       = 1'b0;
        w_busy      = r_busy;
`ifdef VGA_MODE_BLANK_EN
        w_frm_cnt   = r_frm_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_gen_rst_n = 1'b1;
                w_blank     = 1'b0;
                w_busy      = 1'b0;
                // A request still high while our ack is out is the one just served.
                if (i_mode_req && !r_ack) begin
                    if (i_mode_sel != r_cur_mode) begin
                        w_pending = i_mode_sel;
                        w_to_cnt  = '0;
                        w_state   = ST_WAIT;
                        w_busy    = 1'b1;
                    end else begin
                        w_ack = 1'b1;
                    end
                end else begin
                    w_ack = 1'b0;
                end
            end
            ST_WAIT: begin
                if (i_frame_end || (r_to_cnt == TO_LAST)) begin
                    w_timing    = mode_timing(r_pending);
                    w_cur_mode  = r_pending;
                    w_gen_rst_n = 1'b0;
                    w_blank     = 1'b1;
                    w_hold_cnt  = '0;
                    w_state     = ST_HOLD;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_gen_rst_n = 1'b1;
                    if (r_boot) begin
                        w_boot  = 1'b0;
                        w_blank = 1'b0;
                        w_busy  = 1'b0;
                        w_state = ST_IDLE;
                    end else begin
`ifdef VGA_MODE_BLANK_EN
                        w_frm_cnt = '0;
                        w_state   = ST_BLANK;
`else
                        w_ack   = 1'b1;
                        w_blank = 1'b0;
                        w_busy  = 1'b0;
                        w_state = ST_IDLE;
`endif
                    end
                end else begin
                    w_hold_cnt = r_hold_cnt + 1'b1;
                end
            end
`ifdef VGA_MODE_BLANK_EN
            ST_BLANK: begin
                if (i_frame_end) begin
                    if (r_frm_cnt == FRM_LAST) begin
                        w_ack   = 1'b1;
                        w_blank = 1'b0;
                        w_busy  = 1'b0;
                        w_state = ST_IDLE;
                    end else begin
                        w_frm_cnt = r_frm_cnt + 1'b1;
                    end
                end else begin
                    w_frm_cnt = r_frm_cnt;
                end
            end
`endif
            default: begin
                // Unreachable encoding: recover by re-running a generator reset.
                w_state     = ST_HOLD;
                w_hold_cnt  = '0;
                w_gen_rst_n = 1'b0;
                w_blank     = 1'b1;
                w_busy      = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset reloads the default mode and starts the boot hold.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_HOLD;
            r_boot      <= 1'b1;
            r_hold_cnt  <= '0;
            r_to_cnt    <= '0;
            r_pending   <= DEF_MODE;
            r_timing    <= mode_timing(DEF_MODE);
            r_cur_mode  <= DEF_MODE;
            r_gen_rst_n <= 1'b0;
            r_blank     <= 1'b1;
            r_ack       <= 1'b0;
            r_busy      <= 1'b1;
`ifdef VGA_MODE_BLANK_EN
            r_frm_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_boot      <= w_boot;
            r_hold_cnt  <= w_hold_cnt;
            r_to_cnt    <= w_to_cnt;
            r_pending   <= w_pending;
            r_timing    <= w_timing;
            r_cur_mode  <= w_cur_mode;
            r_gen_rst_n <= w_gen_rst_n;
            r_blank     <= w_blank;
            r_ack       <= w_ack;
            r_busy      <= w_busy;
`ifdef VGA_MODE_BLANK_EN
            r_frm_cnt   <= w_frm_cnt;
`endif
        end
    end

    assign o_mode_ack  = r_ack;
    assign o_busy      = r_busy;
    assign o_cur_mode  = r_cur_mode;
    assign o_gen_rst_n = r_gen_rst_n;
    assign o_blank_out = r_blank;
    assign o_h_display = r_timing.hd;
    assign o_h_front   = r_timing.hf;
    assign o_h_sync    = r_timing.hs;
    assign o_h_back    = r_timing.hb;
    assign o_v_display = r_timing.vd;
    assign o_v_front   = r_timing.vf;
    assign o_v_sync    = r_timing.vs;
    assign o_v_back    = r_timing.vb;

endmodule
